mem_store_writer: RTL and testbench

Byte-serial store engine: the write-side counterpart of the instruction-fetch memory controller. Accepts one store request (byte, halfword or word) from the core, then drives the shared 8-bit RAM port one byte per granted cycle with `wr_ram` asserted. It reports completion with a one-cycle `done` pulse. Byte order matches the fetch path: the most significant stored byte goes to the lowest address.

---
 rtl/mem_store_writer_pkg.sv | 35 +++
 rtl/mem_store_writer.sv | 114 +++++++++++
 tb/tb_mem_store_writer.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_store_writer_pkg.sv
// Shared constants and helpers for the byte-serial store writer.
// Store length codes, RAM direction codes and the byte-lane select.
package mem_store_writer_pkg;

   localparam logic [1:0] LEN_BYTE = 2'b00;
   localparam logic [1:0] LEN_HALF = 2'b01;
   localparam logic [1:0] LEN_WORD = 2'b10;

   localparam logic WR_WRITE = 1'b1;
   localparam logic WR_READ  = 1'b0;

   // Index of the final byte of a burst; code 2'b11 behaves as a word.
   function automatic logic [1:0] last_for_len(input logic [1:0] len);
      logic [1:0] last;
      case (len)
         LEN_BYTE: last = 2'd0;
         LEN_HALF: last = 2'd1;
         default:  last = 2'd3;
      endcase
      return last;
   endfunction

   // Byte lane 'lane' of a 32-bit word, lane 0 being bits [7:0].
   function automatic logic [7:0] byte_lane(input logic [31:0] data, input logic [1:0] lane);
      logic [7:0] b;
      case (lane)
         2'd0:    b = data[7:0];
         2'd1:    b = data[15:8];
         2'd2:    b = data[23:16];
         default: b = data[31:24];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/mem_store_writer.sv
// Store engine: latches one byte/half/word store and writes it to an 8-bit RAM
// port, most significant byte at the lowest address, one byte per granted cycle.
module mem_store_writer
   import mem_store_writer_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        store_req,
   input  logic [31:0] store_addr,
   input  logic [31:0] store_data,
   input  logic [1:0]  store_len,
   input  logic        ram_gnt,
   output logic        busy,
   output logic        done,
   output logic [31:0] addr_ram,
   output logic [7:0]  dout_ram,
   output logic        wr_ram
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [1:0]  last_q, last_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] data_q, data_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [31:0] addr_ram_q, addr_ram_d;
   logic [7:0]  dout_ram_q, dout_ram_d;
   logic        wr_q, wr_d;

   // NOTE: every _d gets its hold value first, so no path through the case leaves a latch.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      last_d     = last_q;
      addr_d     = addr_q;
      data_d     = data_q;
      busy_d     = busy_q;
      done_d     = done_q;
      addr_ram_d = addr_ram_q;
      dout_ram_d = dout_ram_q;
      wr_d       = WR_READ;

      case (state_q)
         ST_IDLE: begin
            done_d = 1'b0;
            if (store_req) begin
               addr_d  = store_addr;
               data_d  = store_data;
               last_d  = last_for_len(store_len);
               cnt_d   = 2'd0;
               busy_d  = 1'b1;
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            // Without a grant nothing advances, so the same byte is retried next cycle.
            if (ram_gnt) begin
               addr_ram_d = addr_q + {30'd0, cnt_q};
               dout_ram_d = byte_lane(data_q, last_q - cnt_q);
               wr_d       = WR_WRITE;
               if (cnt_q == last_q) state_d = ST_DONE;
               else                 cnt_d   = cnt_q + 2'd1;
            end
         end
         ST_DONE: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only; reset is synchronous, sampled on the clock edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 2'd0;
         last_q     <= 2'd0;
         addr_q     <= 32'd0;
         data_q     <= 32'd0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         addr_ram_q <= 32'd0;
         dout_ram_q <= 8'd0;
         wr_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         last_q     <= last_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         addr_ram_q <= addr_ram_d;
         dout_ram_q <= dout_ram_d;
         wr_q       <= wr_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign addr_ram = addr_ram_q;
   assign dout_ram = dout_ram_q;
   assign wr_ram   = wr_q;

endmodule

// File: tb/tb_mem_store_writer.sv
// Self-checking bench for mem_store_writer: expected RAM writes go into a queue
// when a store is issued and are popped by a monitor as the DUT writes them.
module tb_mem_store_writer;

   logic        clk = 1'b0;
   logic        rst;
   logic        store_req;
   logic [31:0] store_addr;
   logic [31:0] store_data;
   logic [1:0]  store_len;
   logic        ram_gnt;
   logic        busy;
   logic        done;
   logic [31:0] addr_ram;
   logic [7:0]  dout_ram;
   logic        wr_ram;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [31:0] addr;
      logic [7:0]  data;
   } wr_t;

   wr_t exp_q[$];

   mem_store_writer dut (
      .clk        (clk),
      .rst        (rst),
      .store_req  (store_req),
      .store_addr (store_addr),
      .store_data (store_data),
      .store_len  (store_len),
      .ram_gnt    (ram_gnt),
      .busy       (busy),
      .done       (done),
      .addr_ram   (addr_ram),
      .dout_ram   (dout_ram),
      .wr_ram     (wr_ram)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Monitor: every write cycle must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (wr_ram === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("spurious_write", 32'd1, 32'd0);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("wr_addr", addr_ram, e.addr);
            check("wr_data", {24'd0, dout_ram}, {24'd0, e.data});
         end
      end
   end

   function automatic int nbytes(input logic [1:0] len);
      return (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
   endfunction

   task automatic push_expected(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] len);
      int n;
      wr_t e;
      n = nbytes(len);
      for (int i = 0; i < n; i++) begin
         e.addr = addr + i;
         e.data = 8'(data >> (8 * (n - 1 - i)));
         exp_q.push_back(e);
      end
   endtask

   // Issue a store, apply grant mask (bit k-1 = grant at edge Ek), measure accept-to-done.
   task automatic run_store(input string tag, input logic [31:0] addr, input logic [31:0] data,
                            input logic [1:0] len, input logic [31:0] mask, input int exp_lat);
      int lat;
      push_expected(addr, data, len);
      store_req  = 1'b1;
      store_addr = addr;
      store_data = data;
      store_len  = len;
      @(posedge clk); #1;
      store_req = 1'b0;
      check({tag, "_busy_accept"}, {31'd0, busy}, 32'd1);
      lat = -1;
      for (int k = 1; k <= 30; k++) begin
         ram_gnt = mask[k-1];
         @(posedge clk); #1;
         if (done === 1'b1) begin
            lat = k;
            break;
         end
      end
      ram_gnt = 1'b1;
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
      check({tag, "_wr_at_done"}, {31'd0, wr_ram}, 32'd0);
      @(posedge clk); #1;
      check({tag, "_done_drop"}, {31'd0, done}, 32'd0);
      check({tag, "_sb_empty"}, exp_q.size(), 32'd0);
   endtask

   initial begin
      int lat;
      rst        = 1'b1;
      store_req  = 1'b0;
      store_addr = 32'd0;
      store_data = 32'd0;
      store_len  = 2'b00;
      ram_gnt    = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_addr", addr_ram, 32'd0);
      check("rst_dout", {24'd0, dout_ram}, 32'd0);
      check("rst_wr", {31'd0, wr_ram}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      run_store("word", 32'h100, 32'h11223344, 2'b10, 32'hFFFFFFFF, 5);
      run_store("half", 32'h20, 32'hAAAABEEF, 2'b01, 32'hFFFFFFFF, 3);
      run_store("byte", 32'h7, 32'h0000005A, 2'b00, 32'hFFFFFFFF, 2);
      run_store("stall", 32'h40, 32'h0A0B0C0D, 2'b10, 32'hFFFFFFF3, 7);
      run_store("len11", 32'h500, 32'hDEADBEEF, 2'b11, 32'hFFFFFFFF, 5);

      // Wrap plus request during busy (ignored) held through done (accepted then).
      push_expected(32'hFFFFFFFE, 32'hCAFEBABE, 2'b10);
      store_req  = 1'b1;
      store_addr = 32'hFFFFFFFE;
      store_data = 32'hCAFEBABE;
      store_len  = 2'b10;
      @(posedge clk); #1;
      store_addr = 32'h200;
      store_data = 32'h00000099;
      store_len  = 2'b00;
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (done === 1'b1) begin
            lat = k;
            break;
         end
      end
      check("wrap_latency", lat, 32'd5);
      push_expected(32'h200, 32'h00000099, 2'b00);
      @(posedge clk); #1;
      store_req = 1'b0;
      check("b2b_busy", {31'd0, busy}, 32'd1);
      check("b2b_done_low", {31'd0, done}, 32'd0);
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (done === 1'b1) begin
            lat = k;
            break;
         end
      end
      check("b2b_latency", lat, 32'd2);
      @(posedge clk); #1;
      check("b2b_sb_empty", exp_q.size(), 32'd0);

      // Reset after the second byte of a word: abandoned, no done.
      push_expected(32'h300, 32'h01020304, 2'b10);
      store_req  = 1'b1;
      store_addr = 32'h300;
      store_data = 32'h01020304;
      store_len  = 2'b10;
      @(posedge clk); #1;
      store_req = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrst_sb_left", exp_q.size(), 32'd2);
      exp_q.delete();
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_done", {31'd0, done}, 32'd0);
      check("midrst_addr", addr_ram, 32'd0);
      check("midrst_dout", {24'd0, dout_ram}, 32'd0);
      check("midrst_wr", {31'd0, wr_ram}, 32'd0);
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         check("midrst_no_done", {31'd0, done}, 32'd0);
      end
      run_store("post_rst", 32'h7, 32'h0000005A, 2'b00, 32'hFFFFFFFF, 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: got 0x00000001 expected 0x00000000");
      $fatal(1, "bench timeout");
   end

endmodule
